lab3_keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one row low at a time and sampling the columns.
- Debounces each press and release.
- Emits one-cycle new_key strobe plus stable keypress code; this is the producer of the key/strobe pair consumed by the two-digit display controller.
- Exactly one strobe per physical press; a held key never re-strobes (unless auto-repeat is compiled in).

---
 rtl/lab3_keypad_pkg.sv | 36 +++
 rtl/lab3_sync2.sv | 34 +++
 rtl/lab3_keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_lab3_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab3_keypad_pkg
// Purpose  : Shared types, constants and helpers for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package lab3_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [7:0] NO_KEY    = 8'h00;

  // Larger of two elaboration-time values, used to size the shared counters.
  function automatic int kp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One-hot select of the lowest-index low (pressed) column; col0 wins.
  function automatic logic [3:0] kp_lowest_low(input logic [3:0] c);
    logic [3:0] sel;
    sel = 4'b0000;
    if (!c[0])      sel = 4'b0001;
    else if (!c[1]) sel = 4'b0010;
    else if (!c[2]) sel = 4'b0100;
    else if (!c[3]) sel = 4'b1000;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab3_sync2.sv
`default_nettype none
// ============================================================================
// Module   : lab3_sync2
// Purpose  : Parameterized-width two-flop synchronizer; resets to all ones so
//            pulled-up, active-low inputs read as idle out of reset.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops resolve metastability from the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/lab3_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : lab3_keypad_scanner
// Purpose  : 4x4 matrix keypad scanner. Drives one row low at a time, samples
//            synchronized columns, debounces press and release, and emits a
//            one-cycle new_key strobe with a stable {row,col} one-hot code.
// Options  : define KEYPAD_REPEAT_EN to re-strobe a held key every
//            REPEAT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_keypad_scanner
  import lab3_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [7:0] keypress,
  output logic       new_key
);

`ifdef KEYPAD_REPEAT_EN
  localparam int CNT_MAX = kp_max(kp_max(SCAN_DIV, DEBOUNCE_CYCLES), REPEAT_CYCLES);
`else
  localparam int CNT_MAX = kp_max(SCAN_DIV, DEBOUNCE_CYCLES);
`endif
  localparam int             CNT_W     = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       col_s;
  kp_state_t        state_q,    state_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [CNT_W-1:0] db_cnt_q,   db_cnt_d;
  logic [3:0]       rows_q,     rows_d;
  logic [3:0]       cap_col_q,  cap_col_d;
  logic [7:0]       keypress_q, keypress_d;
  logic             new_key_q,  new_key_d;
  logic [3:0]       rows_next;
  logic             cap_low;

  lab3_sync2 #(.WIDTH(4)) u_col_sync (
    .clk   (int_osc),
    .reset (reset),
    .d     (cols),
    .q     (col_s)
  );

  assign rows_next = {rows_q[2:0], rows_q[3]};
  assign cap_low   = ((col_s & cap_col_q) == 4'b0000);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Repeat counter register; only present when auto-repeat is built in.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end
`else
  // Without auto-repeat the repeat interval has no effect on the hardware.
  if (REPEAT_CYCLES < 1) begin : g_repeat_unused
  end
`endif

  // Next-state logic: scan rows, debounce the captured column, strobe once.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    rows_d     = rows_q;
    cap_col_d  = cap_col_q;
    keypress_d = keypress_q;
    new_key_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
`endif
    case (state_q)
      SCAN: begin
        if (scan_cnt_q >= SCAN_LAST) begin
          scan_cnt_d = '0;
          if (&col_s) begin
            rows_d = rows_next;
          end else begin
            cap_col_d = kp_lowest_low(col_s);
            db_cnt_d  = '0;
            state_d   = PRESS_DB;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (!cap_low) begin
          state_d    = SCAN;
          rows_d     = rows_next;
          scan_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
          keypress_d = {~rows_q, cap_col_q};
          new_key_d  = 1'b1;
          state_d    = HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!cap_low) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_cnt_q >= RPT_LAST) begin
          new_key_d = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
`endif
      end
      RELEASE_DB: begin
        if (cap_low) begin
          state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_cnt_d = '0;
`endif
        end else if (db_cnt_q >= DB_LAST) begin
          state_d    = SCAN;
          rows_d     = rows_next;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State registers with asynchronous reset to the idle scan position.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      rows_q     <= ROW_RESET;
      cap_col_q  <= 4'b0000;
      keypress_q <= NO_KEY;
      new_key_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      rows_q     <= rows_d;
      cap_col_q  <= cap_col_d;
      keypress_q <= keypress_d;
      new_key_q  <= new_key_d;
    end
  end

  assign rows     = rows_q;
  assign keypress = keypress_q;
  assign new_key  = new_key_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab3_keypad_scanner
// Purpose  : Self-checking bench for lab3_keypad_scanner with a keypad matrix
//            model and a strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab3_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int REPEAT_CYCLES   = 32;

  logic        int_osc = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [7:0]  keypress;
  logic        new_key;

  logic [15:0] key_down = 16'h0000;   // bit r*4+c = key at row r, col c pressed
  int          errors     = 0;
  int          checks     = 0;
  int          strobe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_code;
  logic [7:0]  prev_keypress = 8'h00;
  logic        prev_new_key  = 1'b0;

  always #5 int_osc = ~int_osc;

  lab3_keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .keypress (keypress),
    .new_key  (new_key)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  // Monitor: every strobe pops one expected code; keypress must not move otherwise.
  always @(negedge int_osc) begin
    if (!reset) begin
      if (new_key) begin
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: new_key=1 keypress=%b, required no strobe", keypress);
        end else begin
          exp_code = exp_q.pop_front();
          if (keypress !== exp_code) begin
            errors++;
            $display("FAIL strobe_code: keypress=%b required %b", keypress, exp_code);
          end
        end
        checks++;
        if (prev_new_key) begin
          errors++;
          $display("FAIL strobe_back_to_back: new_key high on two cycles, required single-cycle pulse");
        end
      end else begin
        checks++;
        if (keypress !== prev_keypress) begin
          errors++;
          $display("FAIL keypress_without_strobe: keypress=%b previous %b, required unchanged", keypress, prev_keypress);
        end
      end
    end
    prev_keypress = keypress;
    prev_new_key  = new_key;
  end

  task automatic check_rows(input string name, input logic [3:0] exp);
    checks++;
    if (rows !== exp) begin
      errors++;
      $display("FAIL %s: rows=%b required %b", name, rows, exp);
    end
  endtask

  task automatic check_key(input string name, input logic [7:0] exp);
    checks++;
    if (keypress !== exp) begin
      errors++;
      $display("FAIL %s: keypress=%b required %b", name, keypress, exp);
    end
  endtask

  task automatic wait_rows(input string name, input logic [3:0] exp, input int budget);
    int n;
    n = 0;
    while (rows !== exp && n < budget) begin
      @(negedge int_osc);
      n++;
    end
    checks++;
    if (rows !== exp) begin
      errors++;
      $display("FAIL %s: timeout, rows=%b required %b", name, rows, exp);
    end
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int start;
    int n;
    start = strobe_cnt;
    n = 0;
    while (strobe_cnt == start && n < budget) begin
      @(negedge int_osc);
      n++;
    end
    checks++;
    if (strobe_cnt == start) begin
      errors++;
      $display("FAIL %s: timeout, strobes=%0d required %0d", name, strobe_cnt, start + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_r;

    // Reset state
    repeat (3) @(negedge int_osc);
    check_rows("reset_rows", 4'b1110);
    check_key("reset_keypress", 8'h00);
    checks++;
    if (new_key !== 1'b0) begin
      errors++;
      $display("FAIL reset_new_key: new_key=%b required 0", new_key);
    end
    @(posedge int_osc);
    #1 reset = 1'b0;

    // Idle scan: rows rotate every SCAN_DIV cycles
    for (int n = 1; n <= 40; n++) begin
      @(posedge int_osc);
      @(negedge int_osc);
      exp_r = ~(4'b0001 << ((n / 4) % 4));
      check_rows("idle_scan", exp_r);
    end
    check_key("idle_keypress", 8'h00);

    // Short glitch on row2/col1: no strobe, scan resumes at row3
    wait_rows("glitch_pre_row3", 4'b0111, 40);
    wait_rows("glitch_row2", 4'b1011, 40);
    key_down[2*4+1] = 1'b1;
    repeat (7) @(negedge int_osc);
    key_down[2*4+1] = 1'b0;
    repeat (2) @(negedge int_osc);
    check_rows("glitch_rows_frozen", 4'b1011);
    @(negedge int_osc);
    check_rows("glitch_resume_row3", 4'b0111);
    check_key("glitch_keypress", 8'h00);

    // Stable press row2/col1, bounce on release, then stable release
    wait_rows("press_row2", 4'b1011, 40);
    key_down[2*4+1] = 1'b1;
    exp_q.push_back(8'b0100_0010);
    wait_strobe("press_strobe", 60);
    for (int i = 0; i < 20; i++) begin
      @(negedge int_osc);
      check_rows("held_rows", 4'b1011);
    end
    check_key("held_keypress", 8'b0100_0010);
    key_down[2*4+1] = 1'b0;
    repeat (3) @(negedge int_osc);
    key_down[2*4+1] = 1'b1;
    repeat (3) @(negedge int_osc);
    key_down[2*4+1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge int_osc);
      check_rows("release_debounce_rows", 4'b1011);
    end
    @(negedge int_osc);
    check_rows("release_resume_row3", 4'b0111);
    check_key("released_keypress", 8'b0100_0010);

    // Hold row0/col2, add row0/col0: no second strobe
    wait_rows("multi_row0", 4'b1110, 40);
    key_down[0*4+2] = 1'b1;
    exp_q.push_back(8'b0001_0100);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(8'b0001_0100);
`endif
    wait_strobe("multi_strobe", 60);
    key_down[0*4+0] = 1'b1;
    repeat (40) @(negedge int_osc);
    check_rows("multi_rows_frozen", 4'b1110);
    check_key("multi_keypress", 8'b0001_0100);
    key_down = 16'h0000;
    wait_rows("multi_release_scan", 4'b1101, 40);

    // Reset during PRESS_DB at debounce count 5
    wait_rows("rst_pre_row0", 4'b1110, 40);
    wait_rows("rst_row1", 4'b1101, 40);
    key_down[1*4+3] = 1'b1;
    repeat (9) @(negedge int_osc);
    reset = 1'b1;
    #1;
    check_rows("midreset_rows", 4'b1110);
    check_key("midreset_keypress", 8'h00);
    checks++;
    if (new_key !== 1'b0) begin
      errors++;
      $display("FAIL midreset_new_key: new_key=%b required 0", new_key);
    end
    key_down = 16'h0000;
    repeat (3) @(negedge int_osc);
    reset = 1'b0;
    repeat (30) @(negedge int_osc);
    check_key("post_reset_keypress", 8'h00);

    // All expected strobes consumed
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes: %0d expected strobes never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
